// File: rtl/usb_reg_bridge_pkg.sv
// Shared definitions for the SAM3U external-bus to register-strobe bridge.
// Holds the FSM encoding, default widths and the host RDn timing constant.
package usb_reg_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_WR    = 2'd2,
    ST_RD    = 2'd3
  } state_e;

  localparam int DEF_ADDR_WIDTH  = 6;
  localparam int DEF_BCNT_WIDTH  = 16;
  localparam int DEF_SYNC_STAGES = 2;

  // Bit positions of the four asynchronous control pins in the synchroniser bank.
  localparam int SIG_RD   = 0;
  localparam int SIG_WR   = 1;
  localparam int SIG_CEN  = 2;
  localparam int SIG_ALEN = 3;
  localparam int NUM_SIGS = 4;

  // Shortest RDn low time (in clocks) for which usb_dout is already driven.
  function automatic int min_rd_low_clks(input int sync_stages);
    return sync_stages + 3;
  endfunction

  localparam int MIN_RD_LOW_CLKS = DEF_SYNC_STAGES + 3;

endpackage

// File: rtl/usb_reg_bridge_strobe_sync.sv
// Multi-flop synchroniser for one asynchronous strobe pin, with registered
// level and single-cycle rise/fall pulses that are mutually time-aligned.
module usb_strobe_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_usb,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              level_q, level_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;

  // STAGES must be at least 2 so that the first flop can resolve metastability.
  always_comb begin
    sync_d  = {sync_q[STAGES-2:0], din};
    level_d = sync_q[STAGES-1];
    rise_d  = sync_q[STAGES-1] & ~level_q;
    fall_d  = ~sync_q[STAGES-1] & level_q;
  end

  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/usb_reg_bridge.sv
// Bridges the asynchronous SAM3U 8-bit external bus into single-cycle
// register read/write strobes for the register-decode fabric.
module usb_reg_bridge
  import usb_reg_bridge_pkg::*;
#(
  parameter int pADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int pBCNT_WIDTH  = DEF_BCNT_WIDTH,
  parameter int pSYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                   clk_usb,
  input  logic                   reset_n,
  input  logic [7:0]             usb_din,
  output logic [7:0]             usb_dout,
  output logic                   usb_isout,
  input  logic [7:0]             usb_addr,
  input  logic                   usb_rdn,
  input  logic                   usb_wrn,
  input  logic                   usb_cen,
  input  logic                   usb_alen,
  output logic [pADDR_WIDTH-1:0] reg_address,
  output logic [pBCNT_WIDTH-1:0] reg_bytecnt,
  output logic [7:0]             reg_datao,
  input  logic [7:0]             reg_datai,
  output logic                   reg_read,
  output logic                   reg_write,
  output logic                   reg_addrvalid,
  output logic                   proto_err
);

  logic [NUM_SIGS-1:0] pad_n, sync_lvl, sync_rise, sync_fall;

  assign pad_n = {usb_alen, usb_cen, usb_wrn, usb_rdn};

  for (genvar gi = 0; gi < NUM_SIGS; gi++) begin : g_sync
    usb_strobe_sync #(.STAGES(pSYNC_STAGES)) u_sync (
      .clk_usb (clk_usb),
      .reset_n (reset_n),
      .din     (pad_n[gi]),
      .level   (sync_lvl[gi]),
      .rise    (sync_rise[gi]),
      .fall    (sync_fall[gi])
    );
  end

  logic unused_sync;
  assign unused_sync = sync_lvl[SIG_ALEN] ^ sync_rise[SIG_ALEN] ^ sync_fall[SIG_CEN];

  if (pADDR_WIDTH < 8) begin : g_unused_addr
    logic unused_addr;
    assign unused_addr = ^usb_addr[7:pADDR_WIDTH];
  end

  logic cen_low, cen_rise, alen_fall, wr_fall, wr_rise, rd_fall, rd_rise, both_low;

  assign cen_low   = ~sync_lvl[SIG_CEN];
  assign cen_rise  = sync_rise[SIG_CEN];
  assign alen_fall = sync_fall[SIG_ALEN];
  assign wr_fall   = sync_fall[SIG_WR];
  assign wr_rise   = sync_rise[SIG_WR];
  assign rd_fall   = sync_fall[SIG_RD];
  assign rd_rise   = sync_rise[SIG_RD];
  assign both_low  = ~sync_lvl[SIG_RD] & ~sync_lvl[SIG_WR];

  state_e                 state_q, state_d;
  logic [pADDR_WIDTH-1:0] addr_q, addr_d;
  logic [pBCNT_WIDTH-1:0] bcnt_q, bcnt_d;
  logic [7:0]             datao_q, datao_d;
  logic [7:0]             dout_q, dout_d;
  logic                   read_q, read_d;
  logic                   write_q, write_d;
  logic                   isout_q, isout_d;
  logic                   avalid_q, avalid_d;
  logic                   err_q, err_d;

  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      bcnt_q   <= '0;
      datao_q  <= '0;
      dout_q   <= '0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      isout_q  <= 1'b0;
      avalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      bcnt_q   <= bcnt_d;
      datao_q  <= datao_d;
      dout_q   <= dout_d;
      read_q   <= read_d;
      write_q  <= write_d;
      isout_q  <= isout_d;
      avalid_q <= avalid_d;
      err_q    <= err_d;
    end
  end

  // Priority everywhere: CEn release, then address relatch, then RDn+WRn clash.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (cen_low && alen_fall) state_d = ST_ARMED;
      ST_ARMED: begin
        if (cen_rise)                     state_d = ST_IDLE;
        else if (alen_fall || both_low)   state_d = ST_ARMED;
        else if (wr_fall)                 state_d = ST_WR;
        else if (rd_fall)                 state_d = ST_RD;
      end
      ST_WR: begin
        if (cen_rise)                     state_d = ST_IDLE;
        else if (both_low || write_q)     state_d = ST_ARMED;
      end
      ST_RD: begin
        if (cen_rise)                     state_d = ST_IDLE;
        else if (both_low || rd_rise)     state_d = ST_ARMED;
      end
      default:                            state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_d   = addr_q;
    bcnt_d   = bcnt_q;
    datao_d  = datao_q;
    dout_d   = dout_q;
    read_d   = 1'b0;
    write_d  = 1'b0;
    isout_d  = isout_q;
    avalid_d = avalid_q;
    err_d    = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cen_low && alen_fall) begin
          addr_d   = usb_addr[pADDR_WIDTH-1:0];
          bcnt_d   = '0;
          avalid_d = 1'b1;
        end
      end
      ST_ARMED: begin
        if (cen_rise) begin
          avalid_d = 1'b0;
        end else if (alen_fall) begin
          addr_d = usb_addr[pADDR_WIDTH-1:0];
          bcnt_d = '0;
        end else if (both_low) begin
          err_d = 1'b1;
        end else if (!wr_fall && rd_fall) begin
          read_d = 1'b1;
        end
      end
      ST_WR: begin
        if (cen_rise) begin
          avalid_d = 1'b0;
        end else if (both_low) begin
          err_d = 1'b1;
        end else if (write_q) begin
          bcnt_d = bcnt_q + 1'b1;
        end else if (wr_rise) begin
          // Data is stable across the strobe edge, so sample it unsynchronised here.
          datao_d = usb_din;
          write_d = 1'b1;
        end
      end
      ST_RD: begin
        if (cen_rise) begin
          avalid_d = 1'b0;
        end else if (both_low) begin
          err_d = 1'b1;
        end else if (rd_rise) begin
          bcnt_d = bcnt_q + 1'b1;
        end else if (read_q) begin
          dout_d  = reg_datai;
          isout_d = 1'b1;
        end
      end
      default: ;
    endcase
    if (state_d != ST_RD) isout_d = 1'b0;
  end

  assign usb_dout      = dout_q;
  assign usb_isout     = isout_q;
  assign reg_address   = addr_q;
  assign reg_bytecnt   = bcnt_q;
  assign reg_datao     = datao_q;
  assign reg_read      = read_q;
  assign reg_write     = write_q;
  assign reg_addrvalid = avalid_q;
  assign proto_err     = err_q;

endmodule

// File: tb/tb_usb_reg_bridge.sv
// Directed plus randomized bench for usb_reg_bridge against a transaction-level
// model of the host bus (expected address, byte index, data and strobe counts).
module tb_usb_reg_bridge;
  import usb_reg_bridge_pkg::*;

  localparam int AW      = 6;
  localparam int BW      = 4;   // narrow byte counter so wrap-around is reachable quickly
  localparam int SS      = 2;
  localparam int AMASK   = (1 << AW) - 1;
  localparam int BMASK   = (1 << BW) - 1;
  localparam int RD_HOLD = min_rd_low_clks(SS) + 2;

  logic          clk_usb = 1'b0;
  logic          reset_n = 1'b0;
  logic [7:0]    usb_din = 8'h00;
  logic [7:0]    usb_dout;
  logic          usb_isout;
  logic [7:0]    usb_addr = 8'h00;
  logic          usb_rdn = 1'b1, usb_wrn = 1'b1, usb_cen = 1'b1, usb_alen = 1'b1;
  logic [AW-1:0] reg_address;
  logic [BW-1:0] reg_bytecnt;
  logic [7:0]    reg_datao, reg_datai;
  logic          reg_read, reg_write, reg_addrvalid, proto_err;

  usb_reg_bridge #(.pADDR_WIDTH(AW), .pBCNT_WIDTH(BW), .pSYNC_STAGES(SS)) dut (
    .clk_usb(clk_usb), .reset_n(reset_n), .usb_din(usb_din), .usb_dout(usb_dout),
    .usb_isout(usb_isout), .usb_addr(usb_addr), .usb_rdn(usb_rdn), .usb_wrn(usb_wrn),
    .usb_cen(usb_cen), .usb_alen(usb_alen), .reg_address(reg_address),
    .reg_bytecnt(reg_bytecnt), .reg_datao(reg_datao), .reg_datai(reg_datai),
    .reg_read(reg_read), .reg_write(reg_write), .reg_addrvalid(reg_addrvalid),
    .proto_err(proto_err)
  );

  always #5 clk_usb = ~clk_usb;

  // Register fabric stand-in: read data is 0x10 plus the byte index.
  assign reg_datai = 8'h10 + 8'(reg_bytecnt);

  int cyc = 0, wr_cnt = 0, rd_cnt = 0, overlap_cnt = 0, wr_cyc = 0;
  logic [7:0] wr_data = 8'h00;

  always @(posedge clk_usb) cyc <= cyc + 1;

  always @(negedge clk_usb) begin
    if (reset_n) begin
      if (reg_write) begin
        wr_cnt  <= wr_cnt + 1;
        wr_data <= reg_datao;
        wr_cyc  <= cyc;
      end
      if (reg_read) rd_cnt <= rd_cnt + 1;
      if (reg_read && reg_write) overlap_cnt <= overlap_cnt + 1;
    end
  end

  int pass_cnt = 0, chk_cnt = 0;
  int m_addr = 0, m_bcnt = 0;
  logic m_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_usb);
  endtask

  task automatic bus_latch(input logic [7:0] a);
    usb_cen  = 1'b0;
    usb_addr = a;
    usb_alen = 1'b0;
    tick(4);
    usb_alen = 1'b1;
    tick(3);
    m_addr = int'(a) & AMASK;
    m_bcnt = 0;
    check("latch_addr", 32'(reg_address), m_addr);
    check("latch_bcnt", 32'(reg_bytecnt), m_bcnt);
    check("latch_avalid", 32'(reg_addrvalid), 1);
  endtask

  task automatic bus_end();
    usb_cen = 1'b1;
    tick(6);
    check("end_avalid", 32'(reg_addrvalid), 0);
  endtask

  task automatic bus_write(input logic [7:0] d);
    int w0, c0;
    w0 = wr_cnt;
    usb_din = d;
    usb_wrn = 1'b0;
    tick(4);
    c0 = cyc;
    usb_wrn = 1'b1;
    tick(7);
    m_bcnt = (m_bcnt + 1) & BMASK;
    check("wr_count", 32'(wr_cnt - w0), 1);
    check("wr_data", 32'(wr_data), 32'(d));
    check("wr_latency", 32'(wr_cyc - c0), SS + 2);
    check("wr_bcnt", 32'(reg_bytecnt), m_bcnt);
  endtask

  task automatic bus_read();
    int r0;
    logic [7:0] exp;
    r0  = rd_cnt;
    exp = 8'h10 + 8'(m_bcnt);
    check("rd_isout_idle", 32'(usb_isout), 0);
    usb_rdn = 1'b0;
    tick(RD_HOLD);
    check("rd_isout_on", 32'(usb_isout), 1);
    check("rd_dout", 32'(usb_dout), 32'(exp));
    usb_rdn = 1'b1;
    tick(6);
    m_bcnt = (m_bcnt + 1) & BMASK;
    check("rd_isout_off", 32'(usb_isout), 0);
    check("rd_count", 32'(rd_cnt - r0), 1);
    check("rd_bcnt", 32'(reg_bytecnt), m_bcnt);
  endtask

  initial begin
    int w0, r0, op;
    logic seen;

    // Reset state, both during and just after reset.
    tick(3);
    check("rst_outputs", {usb_dout, 7'(reg_address), 4'(reg_bytecnt), reg_datao}, 0);
    check("rst_flags", {28'd0, usb_isout, reg_read, reg_write, reg_addrvalid}, 0);
    reset_n = 1'b1;
    tick(8);
    check("post_rst_flags", {27'd0, usb_isout, reg_read, reg_write, reg_addrvalid, proto_err}, 0);

    // Address latch, single write, 4-byte burst read.
    bus_latch(8'h2A);
    bus_write(8'hA5);
    for (int i = 0; i < 4; i++) bus_read();
    check("burst_bcnt", 32'(reg_bytecnt), 5);

    // Randomized transactions; the narrow counter wraps several times.
    for (int i = 0; i < 40; i++) begin
      op = int'($urandom_range(0, 9));
      if (op == 0) begin
        bus_end();
        bus_latch(8'($urandom));
      end else if (op <= 5) begin
        bus_write(8'($urandom));
      end else begin
        bus_read();
      end
      check("rand_err", 32'(proto_err), 32'(m_err));
    end

    // Deterministic wrap: all-ones to zero without an error.
    bus_end();
    bus_latch(8'h15);
    for (int i = 0; i < BMASK; i++) bus_write(8'(i * 7));
    check("pre_wrap_bcnt", 32'(reg_bytecnt), BMASK);
    bus_write(8'h5C);
    check("wrap_bcnt", 32'(reg_bytecnt), 0);
    check("wrap_err", 32'(proto_err), 0);

    // RDn and WRn low together: no strobes, sticky error, counter untouched.
    w0 = wr_cnt;
    r0 = rd_cnt;
    usb_rdn = 1'b0;
    usb_wrn = 1'b0;
    tick(6);
    usb_rdn = 1'b1;
    usb_wrn = 1'b1;
    tick(6);
    m_err = 1'b1;
    check("clash_wr", 32'(wr_cnt - w0), 0);
    check("clash_rd", 32'(rd_cnt - r0), 0);
    check("clash_err", 32'(proto_err), 1);
    check("clash_bcnt", 32'(reg_bytecnt), m_bcnt);
    bus_write(8'h3C);
    check("err_sticky", 32'(proto_err), 1);

    // CEn released mid-write: no write, back to IDLE, counter untouched.
    w0 = wr_cnt;
    usb_din = 8'hEE;
    usb_wrn = 1'b0;
    tick(5);
    usb_cen = 1'b1;
    tick(5);
    usb_wrn = 1'b1;
    tick(8);
    check("abort_wr", 32'(wr_cnt - w0), 0);
    check("abort_avalid", 32'(reg_addrvalid), 0);
    check("abort_bcnt", 32'(reg_bytecnt), m_bcnt);
    usb_wrn = 1'b0;
    tick(4);
    usb_wrn = 1'b1;
    tick(8);
    check("idle_no_wr", 32'(wr_cnt - w0), 0);

    // Asynchronous reset in the middle of a read.
    bus_latch(8'h33);
    usb_rdn = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(1);
      seen = usb_isout;
    end
    check("pre_rst_isout", 32'(usb_isout), 1);
    #1 reset_n = 1'b0;
    #1;
    check("arst_isout", 32'(usb_isout), 0);
    check("arst_err", 32'(proto_err), 0);
    check("arst_outputs", {usb_dout, 7'(reg_address), 4'(reg_bytecnt), reg_datao}, 0);
    check("arst_flags", {28'd0, reg_read, reg_write, reg_addrvalid, usb_isout}, 0);
    usb_rdn = 1'b1;
    usb_cen = 1'b1;
    tick(3);
    reset_n = 1'b1;
    tick(6);
    check("post_arst_isout", 32'(usb_isout), 0);
    check("no_overlap", 32'(overlap_cnt), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
